key_led_event_ctrl: RTL and testbench

//  N-key debounced input scanner driving M PWM-dimmed LED channels, reporting every

---
 rtl/key_led_event_ctrl_pkg.sv | 27 ++
 rtl/key_led_event_ctrl_debounce.sv | 47 ++++
 rtl/key_led_event_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_key_led_event_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_event_ctrl_pkg.sv
// Shared constants, TX handshake state type and sizing helper for the key/LED event controller.
package key_led_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Cycles WAIT_BUSY tolerates without seeing tx_busy before abandoning the byte
  localparam int unsigned TX_HS_TIMEOUT = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

  // Ceiling log2, never below 1 so the result can always size a vector
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/key_led_event_ctrl_debounce.sv
// One key: 2-FF synchroniser, stability counter and press/release strobes.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int unsigned DB_CYC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2(DB_CYC);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sample;
  logic             settle;

  assign sample = sync_q[1];
  // The counter only runs while the sample disagrees with level, so reaching
  // DB_CYC-1 means DB_CYC consecutive identical samples.
  assign settle = (sample != level) && (cnt_q == CNT_W'(DB_CYC - 1));
  assign rise   = settle & sample;
  assign fall   = settle & ~sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
      if (sample == level) begin
        cnt_q <= '0;
      end else if (settle) begin
        cnt_q <= '0;
        level <= sample;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_led_event_ctrl.sv
// Debounced N-key scanner with per-channel PWM LED dimming, global blank key
// and buffered press/release event reporting to a byte-wide UART transmitter.
module key_led_event_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned NUM_LED        = 3,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned DUTY_STEP      = 32,
  parameter int unsigned LED_ACTIVE_LOW = 1,
  parameter int unsigned EVT_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_LED-1:0]  led,
  output logic [7:0]          tx_data,
  output logic                tx_wr_en,
  input  logic                tx_busy,
  output logic                evt_overflow
);

  localparam int unsigned DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned PTR_W  = clog2(EVT_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [NUM_LED-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_fall;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYC(DB_CYC)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_n[i]),
      .level(key_level[i]),
      .rise (key_rise[i]),
      .fall (key_fall[i])
    );
  end

  // ---------------- pending events and arbiter ----------------
  logic [NUM_KEYS-1:0] pend_q;
  logic [NUM_KEYS-1:0] ptype_q;
  logic [NUM_KEYS-1:0] arb_clr;
  logic                arb_valid;
  logic                arb_type;
  logic [5:0]          arb_idx;

  always_comb begin
    arb_valid = 1'b0;
    arb_type  = EVT_RELEASE;
    arb_idx   = '0;
    arb_clr   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (pend_q[i] && !arb_valid) begin
        arb_valid  = 1'b1;
        arb_type   = ptype_q[i];
        arb_idx    = 6'(i);
        arb_clr[i] = 1'b1;
      end
    end
  end

  // A fresh edge on the key being enqueued stays pending (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      ptype_q <= '0;
    end else begin
      pend_q  <= (pend_q & ~arb_clr) | key_rise | key_fall;
      ptype_q <= (ptype_q & ~(key_rise | key_fall)) | key_rise;
    end
  end

  // ---------------- event FIFO ----------------
  logic [7:0]       fifo_mem [EVT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  tx_state_t        state_q;
  tx_state_t        state_d;

  assign fifo_full  = (fifo_cnt == CNT_W'(EVT_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = (state_q == TX_IDLE) && !fifo_empty && !tx_busy;
  assign push       = arb_valid && (!fifo_full || pop);
  assign drop       = arb_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {arb_type, 1'b0, arb_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(EVT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(EVT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) evt_overflow <= 1'b1;
    end
  end

  // ---------------- duty registers, blank key and PWM ----------------
  logic [NUM_LED-1:0][PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic                             enable_q;
  logic                             en_toggle;
  logic [NUM_LED-1:0]               lit;

  if (NUM_LED < NUM_KEYS) begin : g_blank
    assign en_toggle = key_rise[NUM_LED];
  end else begin : g_no_blank
    assign en_toggle = 1'b0;
  end

  always_comb begin
    lit = '0;
    for (int unsigned c = 0; c < NUM_LED; c++) begin
      lit[c] = enable_q && (pwm_cnt < duty_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      pwm_cnt  <= '0;
      enable_q <= 1'b1;
      led      <= LED_OFF;
    end else begin
      for (int unsigned c = 0; c < NUM_LED; c++) begin
        if (key_rise[c]) duty_q[c] <= duty_q[c] + PWM_BITS'(DUTY_STEP);
      end
      if (en_toggle) enable_q <= ~enable_q;
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= lit ^ LED_OFF;
    end
  end

  // ---------------- TX handshake FSM ----------------
  logic [1:0] wait_q;
  logic [1:0] wait_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      TX_IDLE:      if (pop) state_d = TX_LOAD;
      TX_LOAD: begin
        state_d = TX_WAIT_BUSY;
        wait_d  = '0;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy)                                  state_d = TX_WAIT_DONE;
        else if (wait_q == 2'(TX_HS_TIMEOUT - 1))     state_d = TX_IDLE;
        else                                          wait_d  = wait_q + 1'b1;
      end
      TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  // The strobe is the registered pop, so it is high exactly while in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      wait_q   <= '0;
      tx_wr_en <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tx_wr_en <= pop;
      if (pop) tx_data <= fifo_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_key_led_event_ctrl.sv
// Directed bench: cycle-level behavioural model plus hand-computed byte/PWM/overflow expectations.
module tb_key_led_event_ctrl;

  localparam int NK = 4, NL = 3, DB = 5, STEP = 4, DEPTH = 4, PMOD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level;
  logic [NL-1:0] led;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic          tx_busy = 1'b0;
  logic          evt_overflow;

  int checks = 0;
  int failures = 0;

  key_led_event_ctrl #(
    .NUM_KEYS(NK), .NUM_LED(NL), .CLK_HZ(1000), .DEBOUNCE_MS(5),
    .PWM_BITS(4), .DUTY_STEP(STEP), .LED_ACTIVE_LOW(1), .EVT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_level(key_level), .led(led),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NK-1:0] raw_hist[$];      // raw pressed vectors, index 0 = newest edge
  logic [NK-1:0] m_level, m_pend, m_ptype;
  logic [7:0]    m_q[$];
  int            m_phase, m_quiet, m_tick;
  int            m_duty[NL];
  logic          m_wr, m_ovf, m_en;
  logic [7:0]    m_data;
  logic [NL-1:0] m_led;

  task automatic model_reset();
    raw_hist.delete();
    repeat (8) raw_hist.push_back('0);
    m_level = '0; m_pend = '0; m_ptype = '0;
    m_q.delete();
    m_phase = 0; m_quiet = 0; m_tick = 0;
    for (int c = 0; c < NL; c++) m_duty[c] = 0;
    m_wr = 0; m_ovf = 0; m_en = 1; m_data = 8'h00;
    m_led = '1;
  endtask

  task automatic model_step(input logic [NK-1:0] kn, input logic bz);
    logic [NL-1:0] nl;
    logic [NK-1:0] flip;
    logic          has, pop;
    int            idx;
    logic [7:0]    pd;
    for (int c = 0; c < NL; c++) nl[c] = !(m_en && ((m_tick % PMOD) < m_duty[c]));
    m_tick++;
    raw_hist.push_front(~kn);
    raw_hist.delete(raw_hist.size() - 1);
    // level moves once the last DB synchronised samples all disagree with it
    for (int i = 0; i < NK; i++) begin
      flip[i] = 1'b1;
      for (int j = 2; j < 2 + DB; j++) if (raw_hist[j][i] == m_level[i]) flip[i] = 1'b0;
    end
    pop = (m_phase == 0) && (m_q.size() > 0) && !bz;
    pd = 8'h00;
    if (pop) pd = m_q.pop_front();
    has = 0; idx = 0;
    for (int i = 0; i < NK; i++) if (m_pend[i] && !has) begin has = 1; idx = i; end
    if (has) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_ptype[idx] ? 8'h80 : 8'h00) | 8'(idx));
      else m_ovf = 1;
      m_pend[idx] = 0;
    end
    for (int i = 0; i < NK; i++) begin
      if (flip[i]) begin
        m_level[i] = ~m_level[i];
        m_pend[i] = 1;
        m_ptype[i] = m_level[i];
        if (m_level[i]) begin
          if (i < NL) m_duty[i] = (m_duty[i] + STEP) % PMOD;
          else if (i == NL) m_en = !m_en;
        end
      end
    end
    case (m_phase)
      0: if (pop) begin m_phase = 1; m_data = pd; end
      1: begin m_phase = 2; m_quiet = 0; end
      2: if (bz) m_phase = 3;
         else begin m_quiet++; if (m_quiet == 4) m_phase = 0; end
      default: if (!bz) m_phase = 0;
    endcase
    m_wr = (m_phase == 1);
    m_led = nl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(key_n, tx_busy);
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("key_level", key_level, m_level);
      check("led", led, m_led);
      check("tx_wr_en", tx_wr_en, m_wr);
      check("tx_data", tx_data, m_data);
      check("evt_overflow", evt_overflow, m_ovf);
    end
  end

  // ---------------- UART responder and observation log ----------------
  int         uart_mode = 0;   // 0: busy 10 cycles, 1: busy sticks, 2: never busy
  int         busy_left = 0;
  logic [7:0] wr_log[$];
  int         rise0 = 0;
  logic       prev0 = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      case (uart_mode)
        0: begin
          if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
          end
          if (tx_wr_en) begin tx_busy = 1'b1; busy_left = 10; end
        end
        1: if (tx_wr_en) tx_busy = 1'b1;
        default: begin tx_busy = 1'b0; busy_left = 0; end
      endcase
      if (tx_wr_en) wr_log.push_back(tx_data);
      if (key_level[0] && !prev0) rise0++;
      prev0 = key_level[0];
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input int k);
    key_n[k] = 1'b0; cycles(20);
    key_n[k] = 1'b1; cycles(30);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst key_level", key_level, 0);
    check("rst led", led, 3'b111);
    check("rst tx_wr_en", tx_wr_en, 0);
    check("rst evt_overflow", evt_overflow, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic measure(output int l0, output int l1, output int any);
    l0 = 0; l1 = 0; any = 0;
    repeat (16) begin
      @(negedge clk);
      if (!led[0]) l0++;
      if (!led[1]) l1++;
      if (led != 3'b111) any++;
    end
  endtask

  int base, l0, l1, any;

  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // debounce: short glitch ignored, bounce then steady press gives one rise
    key_n[0] = 1'b0; cycles(3); key_n[0] = 1'b1; cycles(15);
    check("glitch rise0", rise0, 0);
    key_n[0] = 1'b0; cycles(3); key_n[0] = 1'b1; cycles(1);
    key_n[0] = 1'b0; cycles(10);
    check("bounce rise0", rise0, 1);
    cycles(20);
    key_n[0] = 1'b1; cycles(30);
    check("bounce rise0 final", rise0, 1);

    // key 2 press/release reported as 0x82 then 0x02
    base = wr_log.size();
    tap(2);
    check("k2 byte count", wr_log.size(), base + 2);
    if (wr_log.size() >= base + 2) begin
      check("k2 press byte", wr_log[base], 8'h82);
      check("k2 release byte", wr_log[base + 1], 8'h02);
    end

    // simultaneous keys 0 and 1 report lowest index first
    base = wr_log.size();
    key_n = 4'b1100; cycles(50);
    key_n = 4'b1111; cycles(50);
    check("k01 byte count", wr_log.size(), base + 4);
    if (wr_log.size() >= base + 4) begin
      check("k01 byte0", wr_log[base], 8'h80);
      check("k01 byte1", wr_log[base + 1], 8'h81);
      check("k01 byte2", wr_log[base + 2], 8'h00);
      check("k01 byte3", wr_log[base + 3], 8'h01);
    end

    // duty stepping and PWM lit time
    do_reset();
    tap(0); tap(0);
    measure(l0, l1, any);
    check("duty8 lit0", l0, 8);
    tap(0); tap(0);
    measure(l0, l1, any);
    check("duty0 lit0", l0, 0);
    tap(0);
    measure(l0, l1, any);
    check("duty4 lit0", l0, 4);

    // blank key hides all LEDs and restores them with duties kept
    tap(1);
    tap(3);
    measure(l0, l1, any);
    check("blank any lit", any, 0);
    tap(3);
    measure(l0, l1, any);
    check("unblank lit0", l0, 4);
    check("unblank lit1", l1, 4);

    // stuck busy: one byte in flight, four queued, sixth event dropped
    cycles(20);
    uart_mode = 1;
    base = wr_log.size();
    key_n[2] = 1'b0; cycles(15);
    key_n[2] = 1'b1; cycles(12);
    key_n[2] = 1'b0; cycles(12);
    key_n[2] = 1'b1; cycles(12);
    key_n[2] = 1'b0; cycles(12);
    key_n[2] = 1'b1; cycles(12);
    check("stuck overflow", evt_overflow, 1);
    check("stuck byte count", wr_log.size(), base + 1);
    if (wr_log.size() >= base + 1) check("stuck inflight byte", wr_log[base], 8'h82);

    // never busy: queued bytes each strobed once then abandoned
    base = wr_log.size();
    uart_mode = 2;
    cycles(60);
    check("nobusy byte count", wr_log.size(), base + 4);
    if (wr_log.size() >= base + 4) begin
      check("nobusy byte0", wr_log[base], 8'h02);
      check("nobusy byte1", wr_log[base + 1], 8'h82);
      check("nobusy byte2", wr_log[base + 2], 8'h02);
      check("nobusy byte3", wr_log[base + 3], 8'h82);
    end
    check("nobusy overflow sticky", evt_overflow, 1);

    do_reset();
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
